// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite bus codes and slave FSM encoding
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } slave_state_t;

    // Little-endian byte lanes touched by a transfer of the given size
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            HSIZE_BYTE: byte_lanes = 4'b0001 << lo;
            HSIZE_HALF: byte_lanes = lo[1] ? 4'b1100 : 4'b0011;
            default:    byte_lanes = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_slave_mem_if.sv
// rtl/ahb_lite_slave_mem_if.sv - AHB-Lite slave-side bus bundle
interface ahb_lite_slave_mem_if #(
    parameter int ADDR_W = 8
) ();

    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [31:0]       HWDATA;
    logic              HREADY;
    logic              HREADYOUT;
    logic              HRESP;
    logic [31:0]       HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

endinterface

// File: rtl/ahb_slave_regfile.sv
// rtl/ahb_slave_regfile.sv - word storage with byte write enables and combinational read
module ahb_slave_regfile #(
    parameter int DEPTH = 64,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// rtl/ahb_lite_slave_mem.sv - AHB-Lite memory slave with wait states and two-cycle ERROR
module ahb_lite_slave_mem
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ahb_lite_slave_mem_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    slave_state_t      state, state_n;
    logic [3:0]        wait_cnt, wait_cnt_n;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic              write_q;
    logic              can_accept, sample, valid, latch, mem_we;
    logic [31:0]       word_idx;
    logic [31:0]       mem_rdata;
    logic              unused_burst;

    assign unused_burst = ^bus.HBURST;
    assign word_idx     = 32'(bus.HADDR[ADDR_W-1:2]);

    always_comb begin
        valid = (word_idx < 32'(DEPTH));
        if (bus.HSIZE > HSIZE_WORD) begin
            valid = 1'b0;
        end
        if (bus.HSIZE == HSIZE_HALF && bus.HADDR[0]) begin
            valid = 1'b0;
        end
        if (bus.HSIZE == HSIZE_WORD && bus.HADDR[1:0] != 2'b00) begin
            valid = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            size_q   <= HSIZE_BYTE;
            write_q  <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            if (latch) begin
                addr_q  <= bus.HADDR;
                size_q  <= bus.HSIZE;
                write_q <= bus.HWRITE;
            end
        end
    end

    always_comb begin
        state_n       = state;
        wait_cnt_n    = wait_cnt;
        can_accept    = 1'b0;
        sample        = 1'b0;
        latch         = 1'b0;
        mem_we        = 1'b0;
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = HRESP_OKAY;
        bus.HRDATA    = '0;
        case (state)
            ST_IDLE: begin
                can_accept = 1'b1;
            end
            ST_ACCESS: begin
                if (!write_q) begin
                    bus.HRDATA = mem_rdata;
                end
                if (wait_cnt != 4'd0) begin
                    bus.HREADYOUT = 1'b0;
                    wait_cnt_n    = wait_cnt - 4'd1;
                end else begin
                    mem_we     = write_q;
                    can_accept = 1'b1;
                    state_n    = ST_IDLE;
                end
            end
            ST_ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = HRESP_ERROR;
                state_n       = ST_ERR2;
            end
            ST_ERR2: begin
                bus.HRESP  = HRESP_ERROR;
                can_accept = 1'b1;
                state_n    = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        // A completing data phase overlaps the next address phase (pipelined burst)
        sample = can_accept & bus.HSEL & bus.HREADY & bus.HTRANS[1];
        if (sample) begin
            latch = 1'b1;
            if (valid) begin
                state_n    = ST_ACCESS;
                wait_cnt_n = 4'(WAIT_STATES);
            end else begin
                state_n = ST_ERR1;
            end
        end
    end

    ahb_slave_regfile #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk    (HCLK),
        .resetn (HRESETn),
        .we     (mem_we),
        .be     (byte_lanes(size_q, addr_q[1:0])),
        .addr   (addr_q[AW+1:2]),
        .wdata  (bus.HWDATA),
        .rdata  (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// tb/tb_ahb_lite_slave_mem.sv - randomized self-checking bench for ahb_lite_slave_mem
module tb_ahb_lite_slave_mem;
    import ahb_pkg::*;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_lite_slave_mem_if #(.ADDR_W(8)) bus0 ();
    ahb_lite_slave_mem_if #(.ADDR_W(8)) bus1 ();

    ahb_lite_slave_mem #(.ADDR_W(8), .DEPTH(64), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0));
    ahb_lite_slave_mem #(.ADDR_W(8), .DEPTH(48), .WAIT_STATES(2)) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1));

    logic        m_dut;
    logic        m_hsel;
    logic [7:0]  m_addr;
    logic [1:0]  m_trans;
    logic        m_write;
    logic [2:0]  m_size;
    logic [2:0]  m_burst;
    logic [31:0] m_wdata;

    assign bus0.HSEL   = m_hsel & ~m_dut;
    assign bus1.HSEL   = m_hsel & m_dut;
    assign bus0.HADDR  = m_addr;   assign bus1.HADDR  = m_addr;
    assign bus0.HTRANS = m_trans;  assign bus1.HTRANS = m_trans;
    assign bus0.HWRITE = m_write;  assign bus1.HWRITE = m_write;
    assign bus0.HSIZE  = m_size;   assign bus1.HSIZE  = m_size;
    assign bus0.HBURST = m_burst;  assign bus1.HBURST = m_burst;
    assign bus0.HWDATA = m_wdata;  assign bus1.HWDATA = m_wdata;
    assign bus0.HREADY = bus0.HREADYOUT;
    assign bus1.HREADY = bus1.HREADYOUT;

    logic        hready, hresp;
    logic [31:0] hrdata;
    assign hready = m_dut ? bus1.HREADYOUT : bus0.HREADYOUT;
    assign hresp  = m_dut ? bus1.HRESP     : bus0.HRESP;
    assign hrdata = m_dut ? bus1.HRDATA    : bus0.HRDATA;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model [2][64];

    int          n_items;
    logic [7:0]  it_addr  [8];
    logic [2:0]  it_size  [8];
    logic        it_write [8];
    logic [31:0] it_wdata [8];
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d != 0) ? 2 : 0;
    endfunction

    function automatic int depth_of(input int d);
        return (d != 0) ? 48 : 64;
    endfunction

    function automatic bit valid_of(input int d, input int a, input int s);
        if (s > 2) return 1'b0;
        if (s == 1 && (a % 2) != 0) return 1'b0;
        if (s == 2 && (a % 4) != 0) return 1'b0;
        return (a / 4) < depth_of(d);
    endfunction

    task automatic model_write(input int d, input int a, input int s, input logic [31:0] wd);
        bit lane;
        for (int b = 0; b < 4; b++) begin
            if (s == 0)      lane = (b == a % 4);
            else if (s == 1) lane = (b / 2 == (a % 4) / 2);
            else             lane = 1'b1;
            if (lane) model[d][a / 4][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++)
                model[d][w] = '0;
    endtask

    task automatic push(input logic [7:0] a, input logic [2:0] s, input logic w, input logic [31:0] wd);
        it_addr[n_items]  = a;
        it_size[n_items]  = s;
        it_write[n_items] = w;
        it_wdata[n_items] = wd;
        n_items++;
    endtask

    task automatic drive_addr(input int i);
        m_hsel  = 1'b1;
        m_addr  = it_addr[i];
        m_trans = (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        m_write = it_write[i];
        m_size  = it_size[i];
    endtask

    task automatic drive_idle();
        m_hsel  = 1'b0;
        m_trans = HTRANS_IDLE;
        m_write = 1'b0;
    endtask

    // Pipelined master: address of item k+1 overlaps the data phase of item k
    task automatic run_xfers();
        int d, ap, dp, waits, cycles, need;
        bit ok;
        logic hr;
        d = int'(m_dut);
        ap = 0; dp = -1; waits = 0; cycles = 0;
        m_burst = (n_items == 1) ? HBURST_SINGLE : (n_items == 4) ? HBURST_INCR4 : HBURST_INCR;
        @(negedge HCLK);
        drive_addr(0);
        hr = hready;
        while ((ap < n_items || dp >= 0) && cycles < 100) begin
            @(posedge HCLK);
            #1;
            cycles++;
            if (hr) begin
                if (ap < n_items) begin dp = ap; ap++; end
                else dp = -1;
                waits = 0;
                if (ap < n_items) drive_addr(ap);
                else drive_idle();
                if (dp >= 0) m_wdata = it_wdata[dp];
            end
            @(negedge HCLK);
            hr = hready;
            if (dp >= 0) begin
                ok   = valid_of(d, int'(it_addr[dp]), int'(it_size[dp]));
                need = ok ? ws_of(d) : 1;
                check("hreadyout", 32'(hr), 32'(waits == need));
                check("hresp", 32'(hresp), 32'(!ok));
                if (!ok) begin
                    check("err_hrdata", hrdata, 32'h0);
                end else if (hr && it_write[dp]) begin
                    check("wr_hrdata", hrdata, 32'h0);
                    model_write(d, int'(it_addr[dp]), int'(it_size[dp]), it_wdata[dp]);
                end else if (hr) begin
                    check("rd_data", hrdata, model[d][int'(it_addr[dp]) / 4]);
                    last_rdata = hrdata;
                end
                if (!hr) waits++;
            end
        end
        if (ap < n_items || dp >= 0) check("xfer_pending", 32'(ap), 32'(n_items));
        n_items = 0;
    endtask

    task automatic idle_check(input string tag, input logic sel, input logic [1:0] tr);
        @(negedge HCLK);
        m_hsel = sel; m_trans = tr; m_addr = 8'(($urandom % 64) * 4);
        @(negedge HCLK);
        check({tag, "_ready"}, 32'(hready), 32'h1);
        check({tag, "_resp"}, 32'(hresp), 32'h0);
        check({tag, "_rdata"}, hrdata, 32'h0);
        drive_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, s;
        logic [7:0] a;
        m_dut = 1'b0; m_hsel = 1'b0; m_addr = '0; m_trans = HTRANS_IDLE;
        m_write = 1'b0; m_size = HSIZE_WORD; m_burst = HBURST_SINGLE; m_wdata = '0;
        n_items = 0; last_rdata = '0;
        clear_model();

        repeat (2) @(negedge HCLK);
        check("rst_ready0", 32'(bus0.HREADYOUT), 32'h1);
        check("rst_resp0", 32'(bus0.HRESP), 32'h0);
        check("rst_rdata0", bus0.HRDATA, 32'h0);
        check("rst_ready1", 32'(bus1.HREADYOUT), 32'h1);
        check("rst_resp1", 32'(bus1.HRESP), 32'h0);
        check("rst_rdata1", bus1.HRDATA, 32'h0);
        HRESETn = 1'b1;

        // INCR4 write then read on the zero-wait slave
        m_dut = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(8'h10 + 4*i), HSIZE_WORD, 1'b1, 32'(8'hA0 + i));
        run_xfers();
        for (int i = 0; i < 4; i++) push(8'(8'h10 + 4*i), HSIZE_WORD, 1'b0, '0);
        run_xfers();
        check("incr4_last", last_rdata, 32'h000000A3);

        // Two wait states
        m_dut = 1'b1;
        push(8'h20, HSIZE_WORD, 1'b1, 32'hDEADBEEF); run_xfers();
        push(8'h20, HSIZE_WORD, 1'b0, '0);           run_xfers();
        check("ws2_read", last_rdata, 32'hDEADBEEF);

        // Sub-word writes
        m_dut = 1'b0;
        push(8'h21, HSIZE_BYTE, 1'b1, 32'h55555555); push(8'h20, HSIZE_WORD, 1'b0, '0); run_xfers();
        check("byte_write", last_rdata, 32'h00005500);
        push(8'h22, HSIZE_HALF, 1'b1, 32'hBEEFBEEF); push(8'h20, HSIZE_WORD, 1'b0, '0); run_xfers();
        check("half_write", last_rdata, 32'hBEEF5500);

        // Misaligned word write errors and leaves memory alone
        push(8'h02, HSIZE_WORD, 1'b1, 32'hFFFFFFFF); run_xfers();
        push(8'h00, HSIZE_WORD, 1'b0, '0);           run_xfers();
        check("err_nowrite", last_rdata, 32'h0);

        // Back-to-back read-after-write
        push(8'h00, HSIZE_WORD, 1'b1, 32'h12345678); push(8'h00, HSIZE_WORD, 1'b0, '0); run_xfers();
        check("raw", last_rdata, 32'h12345678);

        idle_check("busy", 1'b1, HTRANS_BUSY);
        idle_check("idle_sel", 1'b1, HTRANS_IDLE);
        idle_check("nosel", 1'b0, HTRANS_NONSEQ);

        // Reset during the second wait cycle of a write
        m_dut = 1'b1;
        @(negedge HCLK);
        m_hsel = 1'b1; m_addr = 8'h30; m_trans = HTRANS_NONSEQ; m_write = 1'b1; m_size = HSIZE_WORD;
        @(posedge HCLK); #1;
        drive_idle(); m_wdata = 32'hCAFEF00D;
        @(negedge HCLK);
        check("rstmid_wait1", 32'(hready), 32'h0);
        @(negedge HCLK);
        check("rstmid_wait2", 32'(hready), 32'h0);
        HRESETn = 1'b0;
        #1;
        check("rstmid_ready", 32'(hready), 32'h1);
        check("rstmid_resp", 32'(hresp), 32'h0);
        check("rstmid_rdata", hrdata, 32'h0);
        clear_model();
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        push(8'h30, HSIZE_WORD, 1'b0, '0); run_xfers();
        check("rstmid_word12", last_rdata, 32'h0);

        // Randomized bursts against the reference model
        for (int it = 0; it < 40; it++) begin
            m_dut = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                s = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
                a = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0 && s < 3) a = a & ~8'((1 << s) - 1);
                push(a, 3'(s), 1'($urandom_range(0, 1)), $urandom);
            end
            run_xfers();
            if ($urandom_range(0, 4) == 0) idle_check("rnd_idle", 1'($urandom_range(0, 1)), HTRANS_IDLE);
        end

        // Final sweep of both memories
        for (int d = 0; d < 2; d++) begin
            m_dut = 1'(d);
            for (int w = 0; w < depth_of(d); w += 4) begin
                for (int k = 0; k < 4; k++) push(8'((w + k) * 4), HSIZE_WORD, 1'b0, '0);
                run_xfers();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
